// File: rtl/data_obi_initiator.sv
// Single-command requester for the 33-bit tagged data bus: word or 2-beat capability access.
// Word access returns a response 3 cycles after accept; a capability access takes 4 (zero-wait responder).
module data_obi_initiator #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_be,
  input  logic        cmd_is_cap,
  input  logic [31:0] cmd_addr,
  input  logic [65:0] cmd_wdata,
  output logic        data_req,
  output logic        data_we,
  output logic [3:0]  data_be,
  output logic        data_is_cap,
  output logic [31:0] data_addr,
  output logic [32:0] data_wdata,
  input  logic        data_gnt,
  input  logic        data_rvalid,
  input  logic [32:0] data_rdata,
  input  logic        data_err,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [65:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        proto_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ_LO = 3'd1;
  localparam logic [2:0] S_REQ_HI = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RSP    = 3'd4;
  localparam logic [1:0] MAX_OUT  = 2'(MAX_OUTSTANDING);

  logic [2:0]  state_q, state_d;
  logic [1:0]  out_q, out_d;
  logic        beat_q, beat_d;
  logic        proto_err_q, proto_err_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic        is_cap_q, is_cap_d;
  logic [31:0] addr_q, addr_d;
  logic [65:0] wdata_q, wdata_d;
  logic [65:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic bus_gnt, beat_ok, last_beat, in_lo, in_hi;

  assign in_lo     = (state_q == S_REQ_LO);
  assign in_hi     = (state_q == S_REQ_HI);
  assign data_req  = in_lo | (in_hi & (out_q < MAX_OUT));
  assign bus_gnt   = data_req & data_gnt;
  // Responses with nothing outstanding are protocol violations and never captured.
  assign beat_ok   = data_rvalid & (out_q != 2'd0);
  assign last_beat = is_cap_q ? beat_q : 1'b1;

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    beat_d      = beat_q;
    we_d        = we_q;
    be_d        = be_q;
    is_cap_d    = is_cap_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    proto_err_d = proto_err_q | (data_rvalid & (out_q == 2'd0));

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          we_d     = cmd_we;
          be_d     = cmd_be;
          is_cap_d = cmd_is_cap;
          addr_d   = cmd_addr;
          wdata_d  = cmd_wdata;
          beat_d   = 1'b0;
          rdata_d  = '0;
          err_d    = 1'b0;
          if (cmd_is_cap && (cmd_addr[2:0] != 3'd0)) begin
            err_d   = 1'b1;
            state_d = S_RSP;
          end else begin
            state_d = S_REQ_LO;
          end
        end
      end
      S_REQ_LO: if (bus_gnt) state_d = is_cap_q ? S_REQ_HI : S_WAIT;
      S_REQ_HI: if (bus_gnt) state_d = S_WAIT;
      S_WAIT:   if (beat_ok && last_beat) state_d = S_RSP;
      S_RSP:    if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (beat_ok) begin
      if (!beat_q) rdata_d[32:0]  = data_rdata;
      else         rdata_d[65:33] = data_rdata;
      err_d  = err_d | data_err;
      beat_d = 1'b1;
    end

    case ({bus_gnt, beat_ok})
      2'b10:   out_d = out_q + 2'd1;
      2'b01:   out_d = out_q - 2'd1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_q       <= 2'd0;
      beat_q      <= 1'b0;
      proto_err_q <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'd0;
      is_cap_q    <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 66'd0;
      rdata_q     <= 66'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      beat_q      <= beat_d;
      proto_err_q <= proto_err_d;
      we_q        <= we_d;
      be_q        <= be_d;
      is_cap_q    <= is_cap_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Bus fields are driven only during the address phase, so they idle at zero.
  always_comb begin
    data_we     = 1'b0;
    data_be     = 4'd0;
    data_is_cap = 1'b0;
    data_addr   = 32'd0;
    data_wdata  = 33'd0;
    if (in_lo) begin
      data_we     = we_q;
      data_be     = is_cap_q ? 4'hf : be_q;
      data_is_cap = is_cap_q;
      data_addr   = addr_q;
      data_wdata  = is_cap_q ? wdata_q[32:0] : {1'b0, wdata_q[31:0]};
    end else if (in_hi) begin
      data_we     = we_q;
      data_be     = 4'hf;
      data_is_cap = 1'b1;
      data_addr   = addr_q + 32'd4;
      data_wdata  = wdata_q[65:33];
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? rdata_q : 66'd0;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_data_obi_initiator.sv
// Directed bench: u_dut runs with two beats in flight allowed, u_dut1 with one.
module tb_data_obi_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_valid1;
  logic        cmd_we;
  logic [3:0]  cmd_be;
  logic        cmd_is_cap;
  logic [31:0] cmd_addr;
  logic [65:0] cmd_wdata;
  logic        data_gnt, data_gnt1, data_rvalid, data_rvalid1;
  logic [32:0] data_rdata;
  logic        data_err;
  logic        rsp_ready;

  logic        cmd_ready, data_req, data_we, data_is_cap, rsp_valid, rsp_err, busy, proto_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [32:0] data_wdata;
  logic [65:0] rsp_rdata;

  logic        cmd_ready1, data_req1, data_we1, data_is_cap1, rsp_valid1, rsp_err1, busy1, proto_err1;
  logic [3:0]  data_be1;
  logic [31:0] data_addr1;
  logic [32:0] data_wdata1;
  logic [65:0] rsp_rdata1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_obi_initiator #(.MAX_OUTSTANDING(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_be(cmd_be),
    .cmd_is_cap(cmd_is_cap), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_is_cap(data_is_cap),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .data_err(data_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .proto_err(proto_err)
  );

  data_obi_initiator #(.MAX_OUTSTANDING(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_we(cmd_we), .cmd_be(cmd_be),
    .cmd_is_cap(cmd_is_cap), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .data_req(data_req1), .data_we(data_we1), .data_be(data_be1), .data_is_cap(data_is_cap1),
    .data_addr(data_addr1), .data_wdata(data_wdata1), .data_gnt(data_gnt1),
    .data_rvalid(data_rvalid1), .data_rdata(data_rdata), .data_err(data_err),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
    .busy(busy1), .proto_err(proto_err1)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [3:0] be, input logic cap,
                       input logic [31:0] addr, input logic [65:0] wdata);
    cmd_we = we; cmd_be = be; cmd_is_cap = cap; cmd_addr = addr; cmd_wdata = wdata;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cmd_valid = 0; cmd_valid1 = 0; data_gnt = 0; data_gnt1 = 0;
    data_rvalid = 0; data_rvalid1 = 0; data_rdata = '0; data_err = 0; rsp_ready = 1;
    issue(1'b0, 4'h0, 1'b0, 32'h0, 66'h0);
    #12;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", data_req); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got=%b want=0", proto_err); end
    checks++; if (data_addr !== 32'h0 || data_wdata !== 33'h0 || rsp_rdata !== 66'h0)
      begin errors++; $display("FAIL reset_data got addr=%h wdata=%h rdata=%h want 0", data_addr, data_wdata, rsp_rdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_word_read;
    tick;
    cmd_valid = 1; issue(1'b0, 4'hf, 1'b0, 32'h8000_0010, 66'h0);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_cmd_ready got=%b want=1", cmd_ready); end
    for (int i = 0; i < 3; i++) begin
      tick;
      cmd_valid = 0; data_gnt = (i == 2);
      checks++; if (data_req !== 1'b1 || data_addr !== 32'h8000_0010 || data_be !== 4'hf || data_we !== 1'b0)
        begin errors++; $display("FAIL wr_addr_phase cyc=%0d got req=%b addr=%h be=%h we=%b want 1/80000010/f/0", i, data_req, data_addr, data_be, data_we); end
    end
    tick;
    data_gnt = 0; data_rvalid = 1; data_rdata = 33'h0_1234_5678;
    checks++; if (data_req !== 1'b0 || rsp_valid !== 1'b0)
      begin errors++; $display("FAIL wr_wait got req=%b rsp_valid=%b want 0/0", data_req, rsp_valid); end
    tick;
    data_rvalid = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 66'h0_1234_5678 || rsp_err !== 1'b0)
      begin errors++; $display("FAIL wr_rsp got v=%b d=%h e=%b want 1/12345678/0", rsp_valid, rsp_rdata, rsp_err); end
    tick;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      begin errors++; $display("FAIL wr_idle got rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_cap_write_mo2;
    tick;
    cmd_valid = 1; issue(1'b1, 4'h0, 1'b1, 32'h8000_0100, {33'h1_0000_00BB, 33'h1_0000_00AA});
    tick;
    cmd_valid = 0; data_gnt = 1;
    checks++; if (data_req !== 1'b1 || data_addr !== 32'h8000_0100 || data_be !== 4'hf || data_is_cap !== 1'b1 ||
                  data_wdata !== 33'h1_0000_00AA || data_we !== 1'b1)
      begin errors++; $display("FAIL cw_lo got req=%b addr=%h be=%h cap=%b wd=%h we=%b", data_req, data_addr, data_be, data_is_cap, data_wdata, data_we); end
    tick;
    data_gnt = 1; data_rvalid = 1; data_rdata = 33'h0;
    checks++; if (data_req !== 1'b1 || data_addr !== 32'h8000_0104 || data_be !== 4'hf || data_is_cap !== 1'b1 ||
                  data_wdata !== 33'h1_0000_00BB)
      begin errors++; $display("FAIL cw_hi got req=%b addr=%h be=%h cap=%b wd=%h", data_req, data_addr, data_be, data_is_cap, data_wdata); end
    tick;
    data_gnt = 0; data_rvalid = 1;
    checks++; if (data_req !== 1'b0 || rsp_valid !== 1'b0)
      begin errors++; $display("FAIL cw_wait got req=%b rsp_valid=%b want 0/0", data_req, rsp_valid); end
    tick;
    data_rvalid = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 66'h0 || rsp_err !== 1'b0)
      begin errors++; $display("FAIL cw_rsp got v=%b d=%h e=%b want 1/0/0", rsp_valid, rsp_rdata, rsp_err); end
    tick;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL cw_single_rsp got rsp_valid=%b busy=%b want 0/0", rsp_valid, busy); end
  endtask

  task automatic test_cap_write_mo1;
    tick;
    cmd_valid1 = 1; issue(1'b1, 4'h0, 1'b1, 32'h8000_0100, {33'h1_0000_00BB, 33'h1_0000_00AA});
    tick;
    cmd_valid1 = 0; data_gnt1 = 1;
    checks++; if (data_req1 !== 1'b1 || data_addr1 !== 32'h8000_0100)
      begin errors++; $display("FAIL c1_lo got req=%b addr=%h want 1/80000100", data_req1, data_addr1); end
    tick;
    // Grant offered while req is low must be ignored.
    data_gnt1 = 1; data_rvalid1 = 1; data_rdata = 33'h0;
    checks++; if (data_req1 !== 1'b0)
      begin errors++; $display("FAIL c1_hi_held got req=%b want 0", data_req1); end
    tick;
    data_gnt1 = 1; data_rvalid1 = 0;
    checks++; if (data_req1 !== 1'b1 || data_addr1 !== 32'h8000_0104 || data_wdata1 !== 33'h1_0000_00BB || rsp_valid1 !== 1'b0)
      begin errors++; $display("FAIL c1_hi got req=%b addr=%h wd=%h rv=%b", data_req1, data_addr1, data_wdata1, rsp_valid1); end
    tick;
    data_gnt1 = 0; data_rvalid1 = 1;
    checks++; if (data_req1 !== 1'b0 || rsp_valid1 !== 1'b0)
      begin errors++; $display("FAIL c1_wait got req=%b rsp_valid=%b want 0/0", data_req1, rsp_valid1); end
    tick;
    data_rvalid1 = 0;
    checks++; if (rsp_valid1 !== 1'b1 || rsp_err1 !== 1'b0 || rsp_rdata1 !== 66'h0 || proto_err1 !== 1'b0)
      begin errors++; $display("FAIL c1_rsp got v=%b e=%b d=%h pe=%b want 1/0/0/0", rsp_valid1, rsp_err1, rsp_rdata1, proto_err1); end
    tick;
  endtask

  task automatic test_cap_read;
    logic [32:0] lo, hi;
    lo = 33'h1_AAAA_0001; hi = 33'h0_BBBB_0002;
    tick;
    cmd_valid = 1; issue(1'b0, 4'h0, 1'b1, 32'h8000_0200, 66'h0);
    tick; cmd_valid = 0; data_gnt = 1;
    tick; data_gnt = 1; data_rvalid = 1; data_rdata = lo;
    tick; data_gnt = 0; data_rvalid = 1; data_rdata = hi;
    tick; data_rvalid = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== {hi, lo} || rsp_err !== 1'b0)
      begin errors++; $display("FAIL cr_rsp got v=%b d=%h e=%b want 1/%h/0", rsp_valid, rsp_rdata, rsp_err, {hi, lo}); end
    tick;
  endtask

  task automatic test_byte_write;
    tick;
    cmd_valid = 1; issue(1'b1, 4'b1000, 1'b0, 32'h8000_0203, 66'h1_DEAD_BEEF);
    tick;
    cmd_valid = 0; data_gnt = 1;
    checks++; if (data_wdata !== 33'h0_DEAD_BEEF || data_is_cap !== 1'b0 || data_be !== 4'b1000 || data_addr !== 32'h8000_0203)
      begin errors++; $display("FAIL bw_beat got wd=%h cap=%b be=%b addr=%h want 0deadbeef/0/1000/80000203", data_wdata, data_is_cap, data_be, data_addr); end
    tick; data_gnt = 0; data_rvalid = 1; data_rdata = 33'h0;
    tick; data_rvalid = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 66'h0 || rsp_err !== 1'b0)
      begin errors++; $display("FAIL bw_rsp got v=%b d=%h e=%b want 1/0/0", rsp_valid, rsp_rdata, rsp_err); end
    tick;
  endtask

  task automatic test_misaligned_cap;
    tick;
    cmd_valid = 1; issue(1'b0, 4'h0, 1'b1, 32'h8000_0104, 66'h0);
    tick;
    cmd_valid = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 66'h0 || data_req !== 1'b0)
      begin errors++; $display("FAIL mis_rsp got v=%b e=%b d=%h req=%b want 1/1/0/0", rsp_valid, rsp_err, rsp_rdata, data_req); end
    tick;
    checks++; if (cmd_ready !== 1'b1 || data_req !== 1'b0)
      begin errors++; $display("FAIL mis_idle got cmd_ready=%b req=%b want 1/0", cmd_ready, data_req); end
  endtask

  task automatic test_bus_error;
    tick;
    cmd_valid = 1; issue(1'b0, 4'hf, 1'b0, 32'h0000_1000, 66'h0);
    tick; cmd_valid = 0; data_gnt = 1;
    tick; data_gnt = 0; data_rvalid = 1; data_err = 1; data_rdata = 33'h0_5555_5555;
    tick; data_rvalid = 0; data_err = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 66'h0)
      begin errors++; $display("FAIL err_rsp got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
    tick;
  endtask

  task automatic test_backpressure;
    tick;
    cmd_valid = 1; issue(1'b0, 4'hf, 1'b0, 32'h8000_0020, 66'h0);
    tick; cmd_valid = 0; data_gnt = 1;
    tick; data_gnt = 0; data_rvalid = 1; data_rdata = 33'h0_0000_00C3;
    tick; data_rvalid = 0; rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 66'h0_0000_00C3 || rsp_err !== 1'b0 || cmd_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold cyc=%0d got v=%b d=%h e=%b rdy=%b want 1/c3/0/0", i, rsp_valid, rsp_rdata, rsp_err, cmd_ready); end
      tick;
    end
    rsp_ready = 1;
    tick;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      begin errors++; $display("FAIL bp_release got v=%b rdy=%b want 0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_reset_midflight;
    tick;
    cmd_valid = 1; issue(1'b0, 4'h0, 1'b1, 32'h8000_0300, 66'h0);
    tick; cmd_valid = 0; data_gnt = 1;
    tick; data_gnt = 0;
    checks++; if (data_req !== 1'b1 || data_addr !== 32'h8000_0304 || proto_err !== 1'b0)
      begin errors++; $display("FAIL rst_pre got req=%b addr=%h pe=%b want 1/80000304/0", data_req, data_addr, proto_err); end
    rst_n = 1'b0;
    #1;
    checks++; if (data_req !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || data_addr !== 32'h0 || data_is_cap !== 1'b0)
      begin errors++; $display("FAIL rst_mid got req=%b busy=%b rdy=%b rv=%b addr=%h cap=%b", data_req, busy, cmd_ready, rsp_valid, data_addr, data_is_cap); end
    #2;
    rst_n = 1'b1;
    tick;
    data_rvalid = 1; data_rdata = 33'h0_0000_0777;
    tick;
    data_rvalid = 0;
    checks++; if (proto_err !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL rst_stray got pe=%b rv=%b busy=%b want 1/0/0", proto_err, rsp_valid, busy); end
    tick;
    checks++; if (proto_err !== 1'b1)
      begin errors++; $display("FAIL proto_sticky got pe=%b want 1", proto_err); end
  endtask

  initial begin
    test_reset;
    test_word_read;
    test_cap_write_mo2;
    test_cap_write_mo1;
    test_cap_read;
    test_byte_write;
    test_misaligned_cap;
    test_bus_error;
    test_backpressure;
    test_reset_midflight;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
